// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : Multi-lane load-use and intra-group hazard detector. It keeps
//               a per-register pending-load countdown and holds lanes from the
//               oldest hazarding program-order position onward.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int NUM_LANES          = 2,
    parameter int NUM_REGISTERS_LOG2 = 5,
    parameter int LOAD_LATENCY       = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_LANES-1:0]                      lane_valid,
    input  logic [NUM_LANES*NUM_REGISTERS_LOG2-1:0]   lane_rs,
    input  logic [NUM_LANES*NUM_REGISTERS_LOG2-1:0]   lane_rt,
    input  logic [NUM_LANES*2-1:0]                    lane_src_mask,
    input  logic [NUM_LANES*NUM_REGISTERS_LOG2-1:0]   lane_dst,
    input  logic [NUM_LANES-1:0]                      lane_dst_valid,
    input  logic [NUM_LANES-1:0]                      lane_is_load,
    input  logic [(NUM_LANES > 1 ? $clog2(NUM_LANES) : 1)-1:0] oldest,
    input  logic                                      flush_all,
    output logic [NUM_LANES-1:0]                      stall_lane,
    output logic [NUM_LANES-1:0]                      nop_lane,
    output logic [NUM_LANES-1:0]                      flush_lane,
    output logic [(1 << NUM_REGISTERS_LOG2)-1:0]      busy,
    output logic [15:0]                               stall_cycles
);

    localparam int RW   = NUM_REGISTERS_LOG2;
    localparam int NREG = 1 << NUM_REGISTERS_LOG2;
    localparam int CW   = 3;
    localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_LATENCY);

    logic [NREG*CW-1:0]   cnt_q;
    logic [NREG*CW-1:0]   cnt_d;
    logic [15:0]          stall_cycles_q;
    logic [15:0]          stall_cycles_d;

    logic [NUM_LANES-1:0] hazard;
    logic [NUM_LANES-1:0] held;
    logic                 lane_gate;
    int                   old_i;
    logic [RW-1:0]        rs_idx;
    logic [RW-1:0]        rt_idx;
    logic [RW-1:0]        dst_idx;
    logic                 rs_en;
    logic                 rt_en;

    // Program-order position of a lane relative to the oldest lane.
    function automatic int lane_pos(input int lane, input int old);
        return (lane + NUM_LANES - old) % NUM_LANES;
    endfunction

    assign old_i     = int'(oldest);
    assign lane_gate = !reset && !flush_all;

    for (genvar r = 0; r < NREG; r++) begin : g_busy
        assign busy[r] = |cnt_q[r*CW +: CW];
    end

    always_comb begin
        hazard  = '0;
        rs_idx  = '0;
        rt_idx  = '0;
        dst_idx = '0;
        rs_en   = 1'b0;
        rt_en   = 1'b0;
        for (int j = 0; j < NUM_LANES; j++) begin
            rs_idx = lane_rs[j*RW +: RW];
            rt_idx = lane_rt[j*RW +: RW];
            rs_en  = lane_src_mask[2*j]   && (rs_idx != '0);
            rt_en  = lane_src_mask[2*j+1] && (rt_idx != '0);
            if (lane_valid[j]) begin
                if ((rs_en && busy[rs_idx]) || (rt_en && busy[rt_idx])) begin
                    hazard[j] = 1'b1;
                end
                for (int i = 0; i < NUM_LANES; i++) begin
                    dst_idx = lane_dst[i*RW +: RW];
                    if ((lane_pos(i, old_i) < lane_pos(j, old_i)) && lane_valid[i] &&
                        lane_dst_valid[i] && (dst_idx != '0) &&
                        ((rs_en && (rs_idx == dst_idx)) || (rt_en && (rt_idx == dst_idx)))) begin
                        hazard[j] = 1'b1;
                    end
                end
            end
        end
    end

    // A lane is held when any lane at or before its position hazards.
    always_comb begin
        held = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int m = 0; m < NUM_LANES; m++) begin
                if (hazard[m] && (lane_pos(m, old_i) <= lane_pos(l, old_i))) begin
                    held[l] = 1'b1;
                end
            end
        end
    end

    assign stall_lane   = lane_gate ? held : '0;
    assign nop_lane     = lane_gate ? held : '0;
    assign flush_lane   = (lane_gate && (|held)) ? ~held : '0;
    assign stall_cycles = stall_cycles_q;

    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r*CW +: CW] = (cnt_q[r*CW +: CW] == '0) ? '0 : (cnt_q[r*CW +: CW] - 3'd1);
        end
        // Allocation overrides the decrement on the same edge.
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_gate && !held[l] && lane_valid[l] && lane_is_load[l] &&
                lane_dst_valid[l] && (lane_dst[l*RW +: RW] != '0)) begin
                cnt_d[int'(lane_dst[l*RW +: RW])*CW +: CW] = LOAD_INIT;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((|stall_lane) && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed, table-driven bench for hazard_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  lane_valid;
    logic [9:0]  lane_rs;
    logic [9:0]  lane_rt;
    logic [3:0]  lane_src_mask;
    logic [9:0]  lane_dst;
    logic [1:0]  lane_dst_valid;
    logic [1:0]  lane_is_load;
    logic [0:0]  oldest;
    logic        flush_all;
    logic [1:0]  stall_lane;
    logic [1:0]  nop_lane;
    logic [1:0]  flush_lane;
    logic [31:0] busy;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] valid;
        logic [9:0] rs;
        logic [9:0] rt;
        logic [3:0] mask;
        logic [9:0] dst;
        logic [1:0] dst_valid;
        logic       old;
        logic       flush;
        logic [1:0] e_stall;
        logic [1:0] e_nop;
        logic [1:0] e_flush;
    } vec_t;

    vec_t vecs[11];

    hazard_scoreboard #(
        .NUM_LANES(2),
        .NUM_REGISTERS_LOG2(5),
        .LOAD_LATENCY(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .lane_valid(lane_valid),
        .lane_rs(lane_rs),
        .lane_rt(lane_rt),
        .lane_src_mask(lane_src_mask),
        .lane_dst(lane_dst),
        .lane_dst_valid(lane_dst_valid),
        .lane_is_load(lane_is_load),
        .oldest(oldest),
        .flush_all(flush_all),
        .stall_lane(stall_lane),
        .nop_lane(nop_lane),
        .flush_lane(flush_lane),
        .busy(busy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        lane_valid     = '0;
        lane_rs        = '0;
        lane_rt        = '0;
        lane_src_mask  = '0;
        lane_dst       = '0;
        lane_dst_valid = '0;
        lane_is_load   = '0;
        oldest         = '0;
        flush_all      = 1'b0;
    endtask

    task automatic lane(input int l, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] mask, input logic [4:0] dst, input logic dv,
                        input logic ld);
        lane_valid[l]           = v;
        lane_rs[l*5 +: 5]       = rs;
        lane_rt[l*5 +: 5]       = rt;
        lane_src_mask[l*2 +: 2] = mask;
        lane_dst[l*5 +: 5]      = dst;
        lane_dst_valid[l]       = dv;
        lane_is_load[l]         = ld;
    endtask

    task automatic apply(input vec_t v);
        lane_valid     = v.valid;
        lane_rs        = v.rs;
        lane_rt        = v.rt;
        lane_src_mask  = v.mask;
        lane_dst       = v.dst;
        lane_dst_valid = v.dst_valid;
        lane_is_load   = '0;
        oldest         = v.old;
        flush_all      = v.flush;
    endtask

    initial begin
        // valid, rs, rt, mask, dst, dst_valid, oldest, flush, stall, nop, flush_lane
        vecs[0]  = '{2'b11, {5'd5, 5'd0}, 10'd0, 4'b0100, {5'd0, 5'd5}, 2'b01, 1'b0, 1'b0, 2'b10, 2'b10, 2'b01};
        vecs[1]  = '{2'b11, 10'd0, {5'd0, 5'd7}, 4'b0010, {5'd7, 5'd0}, 2'b10, 1'b1, 1'b0, 2'b01, 2'b01, 2'b10};
        vecs[2]  = '{2'b11, {5'd6, 5'd0}, 10'd0, 4'b0100, {5'd0, 5'd5}, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[3]  = '{2'b11, {5'd5, 5'd0}, 10'd0, 4'b0100, {5'd0, 5'd5}, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[4]  = '{2'b11, {5'd5, 5'd0}, 10'd0, 4'b0000, {5'd0, 5'd5}, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[5]  = '{2'b11, 10'd0, 10'd0, 4'b0100, 10'd0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[6]  = '{2'b10, {5'd5, 5'd0}, 10'd0, 4'b0100, {5'd0, 5'd5}, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[7]  = '{2'b11, {5'd5, 5'd0}, 10'd0, 4'b0100, {5'd0, 5'd5}, 2'b01, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00};
        vecs[8]  = '{2'b11, 10'd0, {5'd9, 5'd0}, 4'b1000, {5'd0, 5'd9}, 2'b01, 1'b0, 1'b0, 2'b10, 2'b10, 2'b01};
        vecs[9]  = '{2'b11, {5'd5, 5'd0}, 10'd0, 4'b0100, {5'd0, 5'd5}, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[10] = '{2'b11, 10'd0, {5'd0, 5'd7}, 4'b0010, {5'd7, 5'd0}, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};

        idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        apply(vecs[0]);
        #1;
        check("reset_busy", busy, 32'h0);
        check("reset_stall_cycles", {16'h0, stall_cycles}, 32'h0);
        check("reset_stall_lane", {30'h0, stall_lane}, 32'h0);
        check("reset_flush_lane", {30'h0, flush_lane}, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        idle();

        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            apply(vecs[k]);
            #2;
            check($sformatf("vec%0d_stall", k), {30'h0, stall_lane}, {30'h0, vecs[k].e_stall});
            check($sformatf("vec%0d_nop", k),   {30'h0, nop_lane},   {30'h0, vecs[k].e_nop});
            check($sformatf("vec%0d_flush", k), {30'h0, flush_lane}, {30'h0, vecs[k].e_flush});
        end

        // Asynchronous reset in the middle of a countdown.
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lane(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1);
        @(negedge clk);
        lane(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b1);
        lane(1, 1'b1, 5'd4, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);
        #2;
        check("sb_lane1_stall", {30'h0, stall_lane}, 32'h2);
        check("sb_lane1_flush", {30'h0, flush_lane}, 32'h1);
        @(negedge clk);
        idle();
        #2;
        check("pre_reset_busy3", {31'h0, busy[3]}, 32'h1);
        check("pre_reset_stall_cycles", {16'h0, stall_cycles}, 32'h1);
        reset = 1'b1;
        #1;
        check("async_reset_busy", busy, 32'h0);
        check("async_reset_stall_cycles", {16'h0, stall_cycles}, 32'h0);

        // Load-use stall across two cycles.
        @(negedge clk);
        reset = 1'b0;
        lane(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b1);
        #2;
        check("lu_c0_stall", {30'h0, stall_lane}, 32'h0);
        @(negedge clk);
        lane(0, 1'b1, 5'd3, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0);
        #2;
        check("lu_c1_busy3", {31'h0, busy[3]}, 32'h1);
        check("lu_c1_stall", {30'h0, stall_lane}, 32'h3);
        check("lu_c1_nop", {30'h0, nop_lane}, 32'h3);
        @(negedge clk);
        #2;
        check("lu_c2_stall", {30'h0, stall_lane}, 32'h3);
        check("lu_c2_nop", {30'h0, nop_lane}, 32'h3);
        @(negedge clk);
        #2;
        check("lu_c3_stall", {30'h0, stall_lane}, 32'h0);
        check("lu_c3_busy3", {31'h0, busy[3]}, 32'h0);
        check("lu_stall_cycles", {16'h0, stall_cycles}, 32'h2);

        // Register 0 is never tracked.
        @(negedge clk);
        idle();
        lane(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1);
        @(negedge clk);
        lane(0, 1'b1, 5'd0, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0);
        #2;
        check("r0_busy", busy, 32'h0);
        check("r0_stall", {30'h0, stall_lane}, 32'h0);

        // Flush squashes outputs and allocation but not the countdown.
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lane(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b1);
        @(negedge clk);
        flush_all = 1'b1;
        lane(0, 1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b1);
        lane(1, 1'b1, 5'd3, 5'd0, 2'b01, 5'd11, 1'b1, 1'b1);
        #2;
        check("fl_stall", {30'h0, stall_lane}, 32'h0);
        check("fl_nop", {30'h0, nop_lane}, 32'h0);
        check("fl_flush", {30'h0, flush_lane}, 32'h0);
        @(negedge clk);
        idle();
        #2;
        check("fl_busy10", {31'h0, busy[10]}, 32'h0);
        check("fl_busy3_pending", {31'h0, busy[3]}, 32'h1);
        check("fl_stall_cycles", {16'h0, stall_cycles}, 32'h0);
        @(negedge clk);
        #2;
        check("fl_busy_drained", busy, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
